// File: rtl/fpadd_pipe_ctrl.sv
// fpadd_pipe_ctrl: issue/stall control for a LATENCY-stage FP adder pipeline.
module fpadd_pipe_ctrl #(
  parameter int LATENCY = 5,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             req1_sub,
  input  logic             flush,
  output logic             op_sel,
  output logic             op_sub,
  output logic             pipe_adv,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_src,
  output logic [3:0]       inflight,
  output logic             busy
);
  logic [LATENCY-1:0] vld, src;
  logic [LATENCY-1:0][TAG_W-1:0] tag;
  logic [TAG_W-1:0] g_tag;
  logic [3:0] cnt;
  logic last_grant, pick, any_grant, leave;
  // pick is the requester that would win; any_grant qualifies it with a free, unflushed slot
  always_comb begin
    pipe_adv = !(vld[LATENCY-1] && !wb_ready);
    pick = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    any_grant = (req0_valid || req1_valid) && pipe_adv && !flush && !rst;
    req0_ready = any_grant && !pick;
    req1_ready = any_grant && pick;
    op_sel = any_grant ? pick : last_grant;
    op_sub = any_grant && (pick ? req1_sub : req0_sub);
    g_tag = any_grant ? (pick ? req1_tag : req0_tag) : {TAG_W{1'b0}};
    leave = vld[LATENCY-1] && wb_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      src <= '0;
      tag <= '0;
      last_grant <= 1'b1;
      cnt <= '0;
    end else if (flush) begin
      vld <= '0;
      cnt <= '0;
    end else if (pipe_adv) begin
      vld <= {vld[LATENCY-2:0], any_grant};
      src <= {src[LATENCY-2:0], any_grant && pick};
      tag <= {tag[LATENCY-2:0], g_tag};
      if (any_grant) last_grant <= pick;
      cnt <= cnt + {3'd0, any_grant} - {3'd0, leave};
    end
  end
  assign wb_valid = vld[LATENCY-1];
  assign wb_tag = tag[LATENCY-1];
  assign wb_src = src[LATENCY-1];
  assign inflight = cnt;
  assign busy = |cnt;
endmodule

// File: tb/tb_fpadd_pipe_ctrl.sv
// tb_fpadd_pipe_ctrl: directed stimulus with a queue scoreboard checked by a writeback monitor.
module tb_fpadd_pipe_ctrl;
  localparam int L = 5;
  localparam int TW = 5;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req0_sub = 0, req1_valid = 0, req1_sub = 0, flush = 0, wb_ready = 1;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic req0_ready, req1_ready, op_sel, op_sub, pipe_adv, wb_valid, wb_src, busy;
  logic [TW-1:0] wb_tag;
  logic [3:0] inflight;
  logic [TW:0] sb[$];
  logic [TW:0] e_mon;
  int n_chk = 0, n_fail = 0;
  int inf_exp[9] = '{0, 1, 1, 2, 2, 2, 1, 1, 0};

  fpadd_pipe_ctrl #(.LATENCY(L), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_tag(req0_tag), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_tag(req1_tag), .req1_sub(req1_sub),
    .flush(flush), .op_sel(op_sel), .op_sub(op_sub), .pipe_adv(pipe_adv),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_src(wb_src),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; req0_sub = 0; req1_sub = 0; flush = 0;
    req0_tag = '0; req1_tag = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); wb_ready = 1; rst = 1;
    next();
    rst = 0;
  endtask

  task automatic drain(input int n);
    idle(); wb_ready = 1;
    repeat (n) next();
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL wb_unexpected: got tag %0d src %0d expected no result", wb_tag, wb_src);
      end else begin
        e_mon = sb.pop_front();
        chk("wb_result", {wb_tag, wb_src}, e_mon);
      end
    end
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0); chk("rst_wb_tag", wb_tag, 0); chk("rst_wb_src", wb_src, 0);
    chk("rst_busy", busy, 0); chk("rst_inflight", inflight, 0); chk("rst_pipe_adv", pipe_adv, 1);
    chk("rst_ready0", req0_ready, 0); chk("rst_ready1", req1_ready, 0);
    next();

    // single op
    req0_valid = 1; req0_tag = 7; req0_sub = 1; sb.push_back({5'd7, 1'b0});
    @(negedge clk);
    chk("single_ready0", req0_ready, 1); chk("single_op_sub", op_sub, 1); chk("single_op_sel", op_sel, 0);
    next();
    idle();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("single_wb_valid", wb_valid, c == 5);
      next();
    end

    // round robin
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req0_valid = 1; req0_tag = 1; req1_valid = 1; req1_tag = 2;
      sb.push_back((c % 2) ? {5'd2, 1'b1} : {5'd1, 1'b0});
      @(negedge clk);
      chk("rr_ready0", req0_ready, c % 2 == 0); chk("rr_ready1", req1_ready, c % 2 == 1);
      chk("rr_op_sel", op_sel, c % 2); chk("rr_inflight", inflight, (c < 5) ? c : 5);
      next();
    end
    idle();
    @(negedge clk); chk("rr_sat", inflight, 5);
    next();
    drain(6);
    @(negedge clk); chk("rr_empty", inflight, 0);
    next();

    // backpressure
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req0_valid = 1; req0_tag = TW'(3 + c);
      sb.push_back({TW'(3 + c), 1'b0});
      next();
    end
    req0_tag = 8; wb_ready = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_pipe_adv", pipe_adv, 0); chk("bp_ready0", req0_ready, 0);
      chk("bp_wb_valid", wb_valid, 1); chk("bp_wb_tag", wb_tag, 3); chk("bp_inflight", inflight, 5);
      next();
    end
    idle(); wb_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_drain_valid", wb_valid, c < 5);
      if (c < 5) chk("bp_drain_tag", wb_tag, 3 + c);
      next();
    end

    // flush
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1; req0_tag = TW'(10 + c);
      next();
    end
    req0_tag = 13; flush = 1;
    @(negedge clk); chk("fl_ready0", req0_ready, 0);
    next();
    flush = 0; sb.push_back({5'd13, 1'b0});
    @(negedge clk);
    chk("fl_inflight", inflight, 0); chk("fl_wb_valid", wb_valid, 0);
    chk("fl_busy", busy, 0); chk("fl_accept", req0_ready, 1);
    next();
    drain(7);

    // reset mid-operation
    do_reset();
    wb_ready = 0;
    for (int c = 0; c < 4; c++) begin
      req0_valid = 1; req0_tag = TW'(20 + c);
      next();
    end
    idle(); rst = 1;
    next();
    rst = 0; req1_valid = 1; req1_tag = 9; sb.push_back({5'd9, 1'b1});
    @(negedge clk);
    chk("mr_wb_valid", wb_valid, 0); chk("mr_inflight", inflight, 0); chk("mr_pipe_adv", pipe_adv, 1);
    chk("mr_ready1", req1_ready, 1); chk("mr_ready0", req0_ready, 0); chk("mr_op_sel", op_sel, 1);
    next();
    drain(7);

    // bubble timing
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0 || c == 2) begin
        req0_valid = 1; req0_tag = TW'(16 + c); sb.push_back({TW'(16 + c), 1'b0});
      end
      @(negedge clk);
      chk("bub_wb_valid", wb_valid, c == 5 || c == 7);
      chk("bub_inflight", inflight, inf_exp[c]);
      next();
    end

    drain(2);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpadd_pipe_ctrl.md
Name: fpadd_pipe_ctrl

Overview:
Issue/stall controller for the 5-stage single-precision FP adder pipeline, whose last stage registers the packed {sign, exp, mant} result. It arbitrates between two requesters (FPU execute port 0 and port 1) and selects which operand set enters stage 1. It tracks valid/tag/source for every in-flight op and drives one global advance enable to all adder stages. It also presents the stage-5 result to writeback with a valid/ready handshake, backpressuring the pipe when writeback stalls.

Parameters:
LATENCY, 5, number of adder pipeline stages (register slots from stage-1 capture to result register); legal 2..8
TAG_W, 5, width of destination tag carried alongside each op (rd index)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an op
req0_ready  output  1  requester 0 op accepted this cycle
req0_tag  input  TAG_W  requester 0 destination tag
req0_sub  input  1  requester 0 op is subtract
req1_valid  input  1  requester 1 has an op
req1_ready  output  1  requester 1 op accepted this cycle
req1_tag  input  TAG_W  requester 1 destination tag
req1_sub  input  1  requester 1 op is subtract
flush  input  1  discard all in-flight ops
op_sel  output  1  operand mux select into stage 1 (0 = req0, 1 = req1)
op_sub  output  1  subtract control for the op entering stage 1
pipe_adv  output  1  global enable for all adder stage registers
wb_valid  output  1  result register holds a valid op
wb_ready  input  1  writeback consumes result
wb_tag  output  TAG_W  tag of the op in the result register
wb_src  output  1  requester index of the op in the result register
inflight  output  4  count of valid ops in pipe (0..LATENCY)
busy  output  1  inflight != 0

Behaviour:
- State: vld[LATENCY-1:0], tag[LATENCY-1:0], src[LATENCY-1:0] shift arrays; last_grant (1 bit); inflight counter.
- Reset values: all vld = 0, tags = 0, src = 0, last_grant = 1 (req0 wins first), inflight = 0.
- Reset output values: wb_valid = 0, wb_tag = 0, wb_src = 0, busy = 0, req*_ready = 0, pipe_adv = 1.
- Reset mid-operation discards all in-flight ops. No wb_valid is produced for them.
- pipe_adv = !(vld[LATENCY-1] && !wb_ready). This is combinational.
- The only stall source is writeback backpressure. Bubbles in earlier slots are not compressed.
- Arbitration (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: round-robin, the requester != last_grant wins.
  - grant is asserted only when pipe_adv = 1 and flush = 0.
  - reqN_ready = grantN. Only one ready may be high per cycle.
- op_sel = granted index. When no grant, op_sel holds last_grant.
- op_sub = selected requester's sub bit, or 0 when no grant.
- On a clock edge with pipe_adv = 1 and flush = 0:
  - Shift: vld/tag/src[i] <= [i-1].
  - Slot 0 <= {any_grant, granted tag, granted index}.
  - last_grant <= granted index if any_grant.
- On a clock edge with pipe_adv = 0: all slots hold and last_grant holds.
- On a clock edge with flush = 1 (overrides pipe_adv):
  - All vld <= 0 and inflight <= 0.
  - No grant that cycle.
  - A result in the last slot is dropped even if wb_ready = 1. Writeback must ignore a handshake in a flush cycle.
- Outputs from the last slot: wb_valid = vld[LATENCY-1], wb_tag = tag[LATENCY-1], wb_src = src[LATENCY-1].
- Latency: op accepted at edge E reaches the last slot at edge E+LATENCY-1. With no stall, wb_valid is high in the following cycle.
- Throughput: 1 op/cycle sustained when wb_ready = 1.
- inflight update per edge: +1 on accept, −1 when the last slot leaves (wb_valid && wb_ready, no flush); net 0 when both occur. inflight never exceeds LATENCY.
- Full pipe with wb_ready = 0: pipe_adv = 0, both readies = 0, all state frozen, wb_valid stays 1 with a stable tag.
- Simultaneous accept and writeback in the same cycle is legal.

Test Plan:
- Single op: rst, then req0_valid = 1, tag = 7, sub = 1 for one cycle. Required: req0_ready = 1 and op_sub = 1 that cycle; wb_valid = 1 with wb_tag = 7 and wb_src = 0 exactly 5 cycles later, for 1 cycle (wb_ready = 1).
- Round robin: both requesters valid continuously for 6 cycles, tags 1 (req0) and 2 (req1). Required: grants alternate 0,1,0,1,0,1; writebacks emerge in the same order; inflight saturates at 5.
- Backpressure: fill the pipe with tags 3..7, then wb_ready = 0 for 4 cycles. Required: pipe_adv = 0, readies = 0, wb_tag frozen at 3, inflight = 5. On wb_ready = 1, tags 3..7 drain one per cycle with no loss or duplication.
- Flush: with 3 ops in flight, assert flush for 1 cycle while req0_valid = 1. Required: req0_ready = 0 in the flush cycle; next cycle inflight = 0, wb_valid = 0, busy = 0; the held req0 op is accepted on the following cycle.
- Reset mid-operation: with 4 ops in flight and wb_ready = 0, assert rst for 1 cycle. Required: wb_valid = 0, inflight = 0, pipe_adv = 1 after the edge; with req1_valid = 1 only, the first grant after reset goes to req1 (sole requester).
- Bubble timing: accepts at cycles 0 and 2 only. Required: wb_valid high at cycles 5 and 7 and low at 6; inflight sequence 1,1,2,2,2,1,1,0.
